trace_access_queue: RTL and testbench
=====================================

// Module: trace_access_queue
// PURPOSE
//  Elastic buffer between the SD trace decoder and the LRU cache controller. The decoder emits one
//  decoded trace line per single-cycle line_ready pulse. The controller stalls on DDR2 misses and
//  evictions and can miss pulses, so lines are queued and released over a valid/ready handshake.
//  The queue also counts instructions consumed and exports back-pressure to the decoder.
// PARAMETERS
//  DEPTH        16  entries; power of two, >=4
//  AFULL_MARGIN 4   in_almost_full asserts when count >= DEPTH-AFULL_MARGIN
//  TAG_W        17  tag width
//  INDEX_W      11  set-index width
//  INST_W       21  instruction-number width
// PORTS
//  clk             in  1        system clock (100 MHz domain)
//  reset           in  1        synchronous, active-high
//  start           in  1        level; pushes are accepted only while high
//  in_tag          in  TAG_W    decoded tag
//  in_index        in  INDEX_W  decoded index
//  in_load_store   in  1        1=store, 0=load
//  in_inst         in  INST_W   decoded instruction number
//  in_line_ready   in  1        1-cycle push strobe
//  in_almost_full  out 1        back-pressure hint to decoder
//  out_valid       out 1        head entry present
//  out_ready       in  1        controller accepts head
//  out_tag/out_index/out_load_store/out_inst  out  widths as above  head entry fields
//  inst_total      out 32       entries popped since reset
//  drop_count      out 16       pushes lost to full queue (STATS_EN)
//  high_water      out clog2(DEPTH)+1  max occupancy seen (STATS_EN)
// BEHAVIOUR
//  - Reset (sync, active-high): rd_ptr=wr_ptr=count=0; out_valid=0, in_almost_full=0,
//    inst_total=0, drop_count=0, high_water=0. Storage is not cleared. Reset mid-stream discards
//    all queued entries; a push or pop in the reset cycle is ignored.
//  - push = in_line_ready & start. pop = out_valid & out_ready.
//  - Push accepted iff count<DEPTH, or pop in the same cycle. Otherwise the entry is dropped and
//    drop_count increments, saturating at 16'hFFFF.
//  - Pulses while start=0 are ignored and are not counted as drops.
//  - First-word fall-through: out_* = mem[rd_ptr]; out_valid = (count!=0).
//    Push-to-out_valid latency is 1 cycle. There is no same-cycle bypass when empty.
//  - out_* fields hold stable while out_valid & ~out_ready. Field values are don't-care when
//    out_valid=0.
//  - Simultaneous push and pop: count unchanged; both pointers advance. Legal when full and when
//    count=1.
//  - Pointers are clog2(DEPTH) bits and wrap modulo DEPTH. count is clog2(DEPTH)+1 bits.
//  - inst_total increments on every pop; 32-bit wrap-around.
//  - in_almost_full is registered from the next-state count.
//  - high_water = max(high_water, count_next), registered.
// CONFIGURATION
//  - TRACE_QUEUE_STATS_EN defined: drop_count and high_water are live as described above.
//  - Not defined: drop_count and high_water are tied to 0; their counters are not synthesised.
//    Drop behaviour itself is unchanged.
// STRUCTURE
//  - trace_queue_pkg.vh holds TAG_W/INDEX_W/INST_W defaults, ENTRY_W=1+TAG_W+INDEX_W+INST_W
//    (50 bits), and the field bit offsets for packing {load_store,tag,index,inst}.
//  - Sub-module trace_queue_mem: DEPTH x ENTRY_W register array with one write port and
//    asynchronous read (LUTRAM). Pointer, count, handshake and stats logic stay in the top.
// TESTING
//  1. Reset, start=1, one pulse {tag=17'h1ABCD, idx=11'h2F5, st=1, inst=21'd7}, out_ready=0
//     -> out_valid=1 the next cycle with identical fields; held 10 cycles; out_ready=1 for one
//     cycle -> out_valid=0, inst_total=1.
//  2. start=0, 5 pulses -> out_valid stays 0 and drop_count=0. Then start=1, 16 pulses
//     (inst=0..15) with out_ready=0 -> in_almost_full rises after the 12th push; count=16.
//  3. Full queue, 3 more pulses, no pop -> drop_count=3. Drain -> inst values 0..15 in order,
//     inst_total=16, high_water=16.
//  4. Full queue, push and pop in the same cycle -> count stays 16, no drop. Popped inst=0;
//     the new entry is tail-most.
//  5. Push 20 and pop 20 interleaved at random -> pointers wrap; output order matches the push
//     scoreboard.
//  6. 8 entries queued, reset asserted 1 cycle alongside a push -> out_valid=0 the next cycle,
//     all counters 0, the pushed entry absent.

Source files
------------

// File: rtl/trace_access_queue_pkg.sv
// Shared defaults for the trace access queue: field widths, packed entry
// layout {load_store, tag, index, inst} and the per-cycle queue operation code.
package trace_access_queue_pkg;

    localparam int DEF_TAG_W   = 17;
    localparam int DEF_INDEX_W = 11;
    localparam int DEF_INST_W  = 21;

    // Bit offsets of each field inside a packed entry with default widths
    localparam int INST_LSB  = 0;
    localparam int INDEX_LSB = INST_LSB + DEF_INST_W;
    localparam int TAG_LSB   = INDEX_LSB + DEF_INDEX_W;
    localparam int LS_BIT    = TAG_LSB + DEF_TAG_W;
    localparam int ENTRY_W   = LS_BIT + 1;

    // {accepted push, pop} for the current cycle
    typedef enum logic [1:0] {
        OP_IDLE = 2'b00,
        OP_POP  = 2'b01,
        OP_PUSH = 2'b10,
        OP_BOTH = 2'b11
    } q_op_e;

    // Packed entry width for arbitrary field widths
    function automatic int entry_width(input int tag_w, input int index_w, input int inst_w);
        return 1 + tag_w + index_w + inst_w;
    endfunction

endpackage

// File: rtl/trace_access_queue_mem.sv
// Entry storage for the trace access queue: DEPTH x ENTRY_W register array,
// one synchronous write port, asynchronous read so the head is visible in
// the same cycle its pointer changes (maps onto LUTRAM).
module trace_access_queue_mem #(
    parameter int DEPTH   = 16,
    parameter int ENTRY_W = 50
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [$clog2(DEPTH)-1:0] waddr,
    input  logic [ENTRY_W-1:0]       wdata,
    input  logic [$clog2(DEPTH)-1:0] raddr,
    output logic [ENTRY_W-1:0]       rdata
);

    logic [ENTRY_W-1:0] mem [DEPTH];

    // Write port; contents are intentionally never cleared
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/trace_access_queue.sv
// trace_access_queue: elastic FIFO between the trace decoder and the cache
// controller. Single-cycle push strobes are queued and released to the
// controller with first-word fall-through over valid/ready.
// Optional statistics (drop_count, high_water) are built only when
// TRACE_QUEUE_STATS_EN is defined; otherwise both outputs read 0.
module trace_access_queue
    import trace_access_queue_pkg::*;
#(
    parameter int DEPTH        = 16,
    parameter int AFULL_MARGIN = 4,
    parameter int TAG_W        = DEF_TAG_W,
    parameter int INDEX_W      = DEF_INDEX_W,
    parameter int INST_W       = DEF_INST_W
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [TAG_W-1:0]         in_tag,
    input  logic [INDEX_W-1:0]       in_index,
    input  logic                     in_load_store,
    input  logic [INST_W-1:0]        in_inst,
    input  logic                     in_line_ready,
    output logic                     in_almost_full,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [TAG_W-1:0]         out_tag,
    output logic [INDEX_W-1:0]       out_index,
    output logic                     out_load_store,
    output logic [INST_W-1:0]        out_inst,
    output logic [31:0]              inst_total,
    output logic [15:0]              drop_count,
    output logic [$clog2(DEPTH):0]   high_water
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam int E_W   = entry_width(TAG_W, INDEX_W, INST_W);

    localparam logic [PTR_W-1:0] PTR_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_ONE   = 1;
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] AFULL_LVL = CNT_W'(DEPTH - AFULL_MARGIN);

    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] count_next;

    logic             push;
    logic             pop;
    logic             push_ok;
    q_op_e            op;

    logic [E_W-1:0]   wdata;
    logic [E_W-1:0]   rdata;

    assign push = in_line_ready & start;
    assign pop  = out_valid & out_ready;
    // A full queue still accepts a push when the head leaves in the same cycle
    assign push_ok = push & ((count < CNT_FULL) | pop);
    assign op      = q_op_e'({push_ok, pop});

    // Occupancy after this cycle's push/pop
    always_comb begin
        count_next = count;
        case (op)
            OP_PUSH: count_next = count + CNT_ONE;
            OP_POP:  count_next = count - CNT_ONE;
            default: count_next = count;
        endcase
    end

    assign wdata = {in_load_store, in_tag, in_index, in_inst};

    trace_access_queue_mem #(
        .DEPTH   (DEPTH),
        .ENTRY_W (E_W)
    ) u_mem (
        .clk   (clk),
        .we    (push_ok & ~reset),
        .waddr (wr_ptr),
        .wdata (wdata),
        .raddr (rd_ptr),
        .rdata (rdata)
    );

    assign out_inst       = rdata[INST_W-1:0];
    assign out_index      = rdata[INST_W +: INDEX_W];
    assign out_tag        = rdata[INST_W+INDEX_W +: TAG_W];
    assign out_load_store = rdata[E_W-1];

    // Pointers, occupancy, handshake flags and the consumed-instruction counter
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            out_valid      <= 1'b0;
            in_almost_full <= 1'b0;
            inst_total     <= 32'd0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr     <= rd_ptr + PTR_ONE;
                inst_total <= inst_total + 32'd1;
            end
            count          <= count_next;
            out_valid      <= (count_next != '0);
            in_almost_full <= (count_next >= AFULL_LVL);
        end
    end

`ifdef TRACE_QUEUE_STATS_EN
    logic             drop;
    logic [15:0]      drop_q;
    logic [CNT_W-1:0] hw_q;

    assign drop = push & ~push_ok;

    // Saturating drop counter and peak-occupancy tracker
    always_ff @(posedge clk) begin
        if (reset) begin
            drop_q <= 16'd0;
            hw_q   <= '0;
        end else begin
            if (drop && (drop_q != 16'hFFFF)) begin
                drop_q <= drop_q + 16'd1;
            end
            if (count_next > hw_q) begin
                hw_q <= count_next;
            end
        end
    end

    assign drop_count = drop_q;
    assign high_water = hw_q;
`else
    assign drop_count = 16'd0;
    assign high_water = '0;
`endif

endmodule

// File: tb/tb_trace_access_queue.sv
// Bench for trace_access_queue: directed vectors plus a queue-based
// reference model compared against the DUT on every negative clock edge.
module tb_trace_access_queue;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [16:0] in_tag;
    logic [10:0] in_index;
    logic        in_load_store;
    logic [20:0] in_inst;
    logic        in_line_ready;
    logic        in_almost_full;
    logic        out_valid;
    logic        out_ready;
    logic [16:0] out_tag;
    logic [10:0] out_index;
    logic        out_load_store;
    logic [20:0] out_inst;
    logic [31:0] inst_total;
    logic [15:0] drop_count;
    logic [4:0]  high_water;

    int n_vec = 0;
    int n_err = 0;

    trace_access_queue dut (
        .clk            (clk),
        .reset          (reset),
        .start          (start),
        .in_tag         (in_tag),
        .in_index       (in_index),
        .in_load_store  (in_load_store),
        .in_inst        (in_inst),
        .in_line_ready  (in_line_ready),
        .in_almost_full (in_almost_full),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tag        (out_tag),
        .out_index      (out_index),
        .out_load_store (out_load_store),
        .out_inst       (out_inst),
        .inst_total     (inst_total),
        .drop_count     (drop_count),
        .high_water     (high_water)
    );

    always #5 clk = ~clk;

    // Reference model: a plain queue of {st, tag, idx, inst} plus counters
    logic [49:0] mq[$];
    int          m_total = 0;
    int          m_drops = 0;
    int          m_hw    = 0;
    bit          m_afull = 1'b0;
    bit          armed   = 1'b0;

    always @(posedge clk) begin
        if (reset) begin
            mq.delete();
            m_total = 0;
            m_drops = 0;
            m_hw    = 0;
            m_afull = 1'b0;
            armed   = 1'b1;
        end else if (armed) begin
            int  sz;
            bit  p_pop;
            bit  p_push;
            sz     = mq.size();
            p_pop  = (sz != 0) && out_ready;
            p_push = in_line_ready && start;
            if (p_pop) begin
                void'(mq.pop_front());
                m_total = m_total + 1;
            end
            if (p_push) begin
                if (sz < 16 || p_pop) mq.push_back({in_load_store, in_tag, in_index, in_inst});
                else if (m_drops < 65535) m_drops = m_drops + 1;
            end
            if (mq.size() > m_hw) m_hw = mq.size();
            m_afull = (mq.size() >= 12);
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_err = n_err + 1;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Compare process: DUT against model on every cycle after reset
    always @(negedge clk) begin
        if (armed && !reset) begin
            chk("out_valid", 64'(out_valid), 64'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("head_fields", 64'({out_load_store, out_tag, out_index, out_inst}), 64'(mq[0]));
            end
            chk("inst_total", 64'(inst_total), 64'(32'(m_total)));
            chk("almost_full", 64'(in_almost_full), 64'(m_afull));
`ifdef TRACE_QUEUE_STATS_EN
            chk("drop_count", 64'(drop_count), 64'(m_drops));
            chk("high_water", 64'(high_water), 64'(m_hw));
`else
            chk("drop_count", 64'(drop_count), 64'd0);
            chk("high_water", 64'(high_water), 64'd0);
`endif
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse(input logic [16:0] t, input logic [10:0] ix, input logic st, input logic [20:0] ins);
        in_tag        = t;
        in_index      = ix;
        in_load_store = st;
        in_inst       = ins;
        in_line_ready = 1'b1;
        tick();
        in_line_ready = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        logic [20:0] last_inst;
        int          pushed;
        int          cyc;
        int          target;

        reset = 1'b1; start = 1'b0; out_ready = 1'b0; in_line_ready = 1'b0;
        in_tag = '0; in_index = '0; in_load_store = 1'b0; in_inst = '0;
        do_reset();
        chk("rst_valid", 64'(out_valid), 64'd0);
        chk("rst_total", 64'(inst_total), 64'd0);
        chk("rst_afull", 64'(in_almost_full), 64'd0);

        // 1: single entry, held, then popped
        start = 1'b1;
        pulse(17'h1ABCD, 11'h2F5, 1'b1, 21'd7);
        chk("t1_valid", 64'(out_valid), 64'd1);
        chk("t1_tag", 64'(out_tag), 64'h1ABCD);
        chk("t1_idx", 64'(out_index), 64'h2F5);
        chk("t1_st", 64'(out_load_store), 64'd1);
        chk("t1_inst", 64'(out_inst), 64'd7);
        for (int i = 0; i < 10; i++) tick();
        chk("t1_hold_inst", 64'(out_inst), 64'd7);
        chk("t1_hold_tag", 64'(out_tag), 64'h1ABCD);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t1_pop_valid", 64'(out_valid), 64'd0);
        chk("t1_pop_total", 64'(inst_total), 64'd1);

        // 2: pulses with start low are ignored; then fill to 16
        do_reset();
        start = 1'b0;
        for (int i = 0; i < 5; i++) pulse(17'h5, 11'h5, 1'b0, 21'd99);
        chk("t2_ign_valid", 64'(out_valid), 64'd0);
        chk("t2_ign_drop", 64'(drop_count), 64'd0);
        start = 1'b1;
        for (int i = 0; i < 16; i++) begin
            pulse(17'(i * 3), 11'(i), i[0], 21'(i));
            if (i == 10) chk("t2_afull_11", 64'(in_almost_full), 64'd0);
            if (i == 11) chk("t2_afull_12", 64'(in_almost_full), 64'd1);
        end
        chk("t2_model_size", 64'(mq.size()), 64'd16);
        chk("t2_valid", 64'(out_valid), 64'd1);

        // 3: three drops on a full queue, then drain in order
        for (int i = 0; i < 3; i++) pulse(17'h1FFFF, 11'h7FF, 1'b1, 21'd500);
`ifdef TRACE_QUEUE_STATS_EN
        chk("t3_drops", 64'(drop_count), 64'd3);
`else
        chk("t3_drops", 64'(drop_count), 64'd0);
`endif
        out_ready = 1'b1;
        for (int i = 0; i < 16; i++) begin
            chk("t3_order", 64'(out_inst), 64'(i));
            tick();
        end
        out_ready = 1'b0;
        chk("t3_empty", 64'(out_valid), 64'd0);
        chk("t3_total", 64'(inst_total), 64'd16);
`ifdef TRACE_QUEUE_STATS_EN
        chk("t3_hw", 64'(high_water), 64'd16);
`else
        chk("t3_hw", 64'(high_water), 64'd0);
`endif

        // 4: push and pop together while full
        for (int i = 0; i < 16; i++) pulse(17'(i), 11'(i), 1'b0, 21'(100 + i));
        chk("t4_head", 64'(out_inst), 64'd100);
        out_ready = 1'b1;
        pulse(17'h0AAAA, 11'h155, 1'b1, 21'd200);
        out_ready = 1'b0;
        chk("t4_size", 64'(mq.size()), 64'd16);
        chk("t4_afull", 64'(in_almost_full), 64'd1);
        chk("t4_next_head", 64'(out_inst), 64'd101);
`ifdef TRACE_QUEUE_STATS_EN
        chk("t4_no_drop", 64'(drop_count), 64'd3);
`else
        chk("t4_no_drop", 64'(drop_count), 64'd0);
`endif
        out_ready = 1'b1;
        last_inst = '0;
        for (int i = 0; i < 16; i++) begin
            last_inst = out_inst;
            tick();
        end
        out_ready = 1'b0;
        chk("t4_tail", 64'(last_inst), 64'd200);
        chk("t4_empty", 64'(out_valid), 64'd0);

        // 5: random interleave of 20 pushes and 20 pops, pointers wrap
        pushed = 0;
        cyc    = 0;
        target = m_total + 20;
        while (m_total < target && cyc < 600) begin
            in_line_ready = (pushed < 20) && (mq.size() < 15) && ($urandom_range(0, 1) == 1);
            if (in_line_ready) begin
                in_tag        = 17'($urandom);
                in_index      = 11'($urandom);
                in_load_store = 1'($urandom);
                in_inst       = 21'(300 + pushed);
                pushed        = pushed + 1;
            end
            out_ready = (pushed >= 20) || ($urandom_range(0, 1) == 1);
            tick();
            cyc = cyc + 1;
        end
        in_line_ready = 1'b0;
        out_ready     = 1'b0;
        chk("t5_pops", 64'(inst_total), 64'(32'(target)));

        // 6: reset with a push in the same cycle discards everything
        for (int i = 0; i < 8; i++) pulse(17'(i), 11'(i), 1'b1, 21'(400 + i));
        chk("t6_queued", 64'(out_valid), 64'd1);
        reset = 1'b1;
        pulse(17'h12345, 11'h123, 1'b1, 21'd999);
        reset = 1'b0;
        chk("t6_valid", 64'(out_valid), 64'd0);
        chk("t6_total", 64'(inst_total), 64'd0);
        chk("t6_afull", 64'(in_almost_full), 64'd0);
        chk("t6_drop", 64'(drop_count), 64'd0);
        chk("t6_hw", 64'(high_water), 64'd0);
        tick();
        chk("t6_absent", 64'(out_valid), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
